// File: rtl/d_branch_pkg.sv
// d_branch_pkg
//   Shared definitions for the decode-stage branch resolver:
//   - compare-op codes driven on d_cmp_op
//   - 2-bit saturating counter encodings used by the branch history table
package d_branch_pkg;

    // Compare op codes. Any code outside this set resolves as not-taken.
    localparam logic [3:0] CMP_EQ  = 4'd0;
    localparam logic [3:0] CMP_OPP = 4'd1;
    localparam logic [3:0] CMP_NE  = 4'd2;
    localparam logic [3:0] CMP_LEZ = 4'd3;
    localparam logic [3:0] CMP_GTZ = 4'd4;
    localparam logic [3:0] CMP_LTZ = 4'd5;
    localparam logic [3:0] CMP_GEZ = 4'd6;
    localparam logic [3:0] CMP_LT  = 4'd7;
    localparam logic [3:0] CMP_LTU = 4'd8;

    // Branch history counter states; bit 1 is the taken prediction.
    localparam logic [1:0] CNT_SNT = 2'd0;  // strongly not-taken
    localparam logic [1:0] CNT_WNT = 2'd1;  // weakly not-taken (reset value)
    localparam logic [1:0] CNT_WT  = 2'd2;  // weakly taken
    localparam logic [1:0] CNT_ST  = 2'd3;  // strongly taken

    // Saturating counter step toward taken / not-taken.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// bht_2bit
//   Branch history table of 2**IDX_W two-bit saturating counters.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset (all entries -> weakly not-taken)
//     rd_idx / rd_cnt   combinational read port (returns the pre-update value on a
//                       same-cycle read/write of one entry; no bypass)
//     wr_idx, wr_en,    update port: on a clock edge with wr_en, entry wr_idx steps
//     wr_taken          toward taken (wr_taken=1) or not-taken, saturating
module bht_2bit
    import d_branch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_en,
    input  logic             wr_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] cnt [DEPTH];

    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= CNT_WNT;
            end
        end else if (wr_en) begin
            cnt[wr_idx] <= cnt_next(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/d_branch_resolver.sv
// d_branch_resolver
//   Decode-stage branch resolution: predicts in F from the BHT, carries the
//   prediction into D, resolves the branch condition in D, trains the BHT,
//   flags mispredicts, drives the likely-branch delay-slot annul and keeps
//   resolved-branch / mispredict statistics.
//   Ports:
//     clk, reset            clock, asynchronous active-low reset
//     f_idx, f_is_br        BHT index and branch flag of the F instruction
//     stall                 D held this cycle (D regs hold, no update, no count)
//     flush                 no instruction enters D (carried prediction cleared)
//     d_valid               D instruction is a conditional branch
//     d_cmp_op, a, b        compare op and forwarded operands
//     f_pred                prediction for F (combinational)
//     d_branch              resolved condition (combinational)
//     d_mispredict          resolved branch disagrees with carried prediction
//     d_cleardb             annul delay slot of a not-taken likely branch
//     br_count, mp_count    wrapping statistics counters
module d_branch_resolver
    import d_branch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] f_idx,
    input  logic             f_is_br,
    input  logic             stall,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [3:0]       d_cmp_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             f_pred,
    output logic             d_branch,
    output logic             d_mispredict,
    output logic             d_cleardb,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       f_cnt;
    logic             d_pred;
    logic [IDX_W-1:0] d_idx;
    logic             resolve;
    logic [WIDTH-1:0] sum;

    bht_2bit #(.IDX_W(IDX_W)) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (f_idx),
        .rd_cnt   (f_cnt),
        .wr_idx   (d_idx),
        .wr_en    (resolve),
        .wr_taken (d_branch)
    );

    assign f_pred  = f_cnt[1] & f_is_br;
    assign resolve = d_valid & ~stall;
    assign sum     = a + b;

    // Branch condition. OPP is "b is the negation of a"; MIN_INT is its own
    // two's-complement negation, so that pair is excluded explicitly.
    always_comb begin
        d_branch = 1'b0;
        case (d_cmp_op)
            CMP_EQ:  d_branch = (a == b);
            CMP_OPP: d_branch = (sum == '0) && !((a == MIN_INT) && (b == MIN_INT));
            CMP_NE:  d_branch = (a != b);
            CMP_LEZ: d_branch = a[WIDTH-1] || (a == '0);
            CMP_GTZ: d_branch = !a[WIDTH-1] && (a != '0);
            CMP_LTZ: d_branch = a[WIDTH-1];
            CMP_GEZ: d_branch = !a[WIDTH-1];
            CMP_LT:  d_branch = ($signed(a) < $signed(b));
            CMP_LTU: d_branch = (a < b);
            default: d_branch = 1'b0;
        endcase
    end

    assign d_mispredict = resolve & (d_branch != d_pred);
    assign d_cleardb    = resolve & (d_cmp_op == CMP_OPP) & ~d_branch;

    // F->D carry; stall takes priority over flush so a held branch keeps its prediction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_pred <= 1'b0;
            d_idx  <= '0;
        end else if (!stall) begin
            d_pred <= flush ? 1'b0 : f_pred;
            d_idx  <= f_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count <= '0;
            mp_count <= '0;
        end else begin
            if (resolve)      br_count <= br_count + CNT_W'(1);
            if (d_mispredict) mp_count <= mp_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_d_branch_resolver.sv
module tb_d_branch_resolver;

    localparam int WIDTH = 32;
    localparam int IDX_W = 6;
    localparam int CNT_W = 8;
    localparam int DEPTH = 64;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [IDX_W-1:0] f_idx = '0;
    logic             f_is_br = 1'b0;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic             d_valid = 1'b0;
    logic [3:0]       d_cmp_op = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             f_pred, d_branch, d_mispredict, d_cleardb;
    logic [CNT_W-1:0] br_count, mp_count;

    d_branch_resolver #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .f_idx        (f_idx),
        .f_is_br      (f_is_br),
        .stall        (stall),
        .flush        (flush),
        .d_valid      (d_valid),
        .d_cmp_op     (d_cmp_op),
        .a            (a),
        .b            (b),
        .f_pred       (f_pred),
        .d_branch     (d_branch),
        .d_mispredict (d_mispredict),
        .d_cleardb    (d_cleardb),
        .br_count     (br_count),
        .mp_count     (mp_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_bht [DEPTH];   // counter value 0..3 per entry
    int m_d_pred;
    int m_d_idx;
    int m_br;
    int m_mp;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_d_pred = 0;
        m_d_idx  = 0;
        m_br     = 0;
        m_mp     = 0;
    endfunction

    function automatic bit ref_branch(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        s  = 64'(x) + 64'(y);
        case (op)
            4'd0: return x == y;
            4'd1: return (s[31:0] == 32'd0) && !(x == MIN && y == MIN);
            4'd2: return x != y;
            4'd3: return sx <= 0;
            4'd4: return sx > 0;
            4'd5: return sx < 0;
            4'd6: return sx >= 0;
            4'd7: return sx < sy;
            4'd8: return longint'(x) < longint'(y);
            default: return 0;
        endcase
    endfunction

    bit obs_branch, obs_cleardb, obs_pred;

    // One cycle: drive at negedge, check combinational outputs just after,
    // then advance the model across the rising edge.
    task automatic step(input int fi, input bit fb, input bit st, input bit fl,
                        input bit dv, input int op, input logic [31:0] va, input logic [31:0] vb);
        bit e_pred, e_br, e_mp, e_cl, resolve;
        f_idx = IDX_W'(fi); f_is_br = fb; stall = st; flush = fl;
        d_valid = dv; d_cmp_op = 4'(op); a = va; b = vb;
        #1;
        e_pred  = (m_bht[fi] >= 2) && fb;
        e_br    = ref_branch(4'(op), va, vb);
        resolve = dv && !st;
        e_mp    = resolve && (e_br != (m_d_pred != 0));
        e_cl    = resolve && (op == 1) && !e_br;
        obs_branch = d_branch; obs_cleardb = d_cleardb; obs_pred = f_pred;
        check("f_pred", 64'(f_pred), 64'(e_pred));
        check("d_branch", 64'(d_branch), 64'(e_br));
        check("d_mispredict", 64'(d_mispredict), 64'(e_mp));
        check("d_cleardb", 64'(d_cleardb), 64'(e_cl));
        check("br_count", 64'(br_count), 64'(m_br));
        check("mp_count", 64'(mp_count), 64'(m_mp));
        @(posedge clk);
        if (resolve) begin
            if (e_br) m_bht[m_d_idx] = (m_bht[m_d_idx] == 3) ? 3 : m_bht[m_d_idx] + 1;
            else      m_bht[m_d_idx] = (m_bht[m_d_idx] == 0) ? 0 : m_bht[m_d_idx] - 1;
            m_br = (m_br + 1) % (1 << CNT_W);
            if (e_mp) m_mp = (m_mp + 1) % (1 << CNT_W);
        end
        if (!st) begin
            m_d_pred = fl ? 0 : int'(e_pred);
            m_d_idx  = fi;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0; flush = 1'b0; d_valid = 1'b0; f_is_br = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            f_idx = IDX_W'(i * 17);
            #1;
            check("rst_f_pred", 64'(f_pred), 64'(0));
        end
        check("rst_br_count", 64'(br_count), 64'(0));
        check("rst_mp_count", 64'(mp_count), 64'(0));
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return MIN;
            2: return 32'($urandom_range(0, 8));
            3: return -32'($urandom_range(0, 8));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- comparator vectors ----------------
    typedef struct {
        int          op;
        logic [31:0] va;
        logic [31:0] vb;
        bit          exp_br;
        bit          exp_cl;
    } vec_t;

    vec_t vecs [$];

    initial begin
        vecs = '{
            '{0, 32'd7, 32'd7, 1, 0},      '{0, 32'd7, 32'd8, 0, 0},
            '{1, 32'd3, -32'd3, 1, 0},     '{1, 32'd3, 32'd3, 0, 1},
            '{1, MIN, MIN, 0, 1},          '{1, 32'd0, 32'd0, 1, 0},
            '{2, 32'd1, 32'd2, 1, 0},      '{2, 32'd5, 32'd5, 0, 0},
            '{3, 32'd0, 32'd0, 1, 0},      '{3, -32'd1, 32'd0, 1, 0},
            '{3, 32'd1, 32'd0, 0, 0},      '{4, 32'd0, 32'd0, 0, 0},
            '{4, 32'd5, 32'd0, 1, 0},      '{4, MIN, 32'd0, 0, 0},
            '{5, MIN, 32'd0, 1, 0},        '{5, 32'd0, 32'd0, 0, 0},
            '{6, 32'd0, 32'd0, 1, 0},      '{6, -32'd1, 32'd0, 0, 0},
            '{7, 32'd1, -32'd1, 0, 0},     '{7, -32'd1, 32'd1, 1, 0},
            '{8, 32'd1, -32'd1, 1, 0},     '{8, -32'd1, 32'd1, 0, 0},
            '{15, 32'd7, 32'd7, 0, 0},     '{9, 32'd0, 32'd0, 0, 0}
        };

        @(negedge clk);
        do_reset();

        // BHT training at index 5: two taken, then one not-taken.
        step(5, 1, 0, 0, 0, 0, 32'd0, 32'd0);            // D gets idx 5, pred 0
        step(5, 1, 0, 0, 1, 0, 32'd7, 32'd7);            // taken, entry 1->2
        check("t2_f_pred_no_bypass", 64'(obs_pred), 64'(0));
        step(5, 1, 0, 0, 1, 0, 32'd7, 32'd7);            // taken, entry 2->3
        check("t2_f_pred_after_1st", 64'(obs_pred), 64'(1));
        step(5, 1, 0, 0, 1, 0, 32'd7, 32'd8);            // not taken, entry 3->2
        step(5, 1, 0, 0, 0, 0, 32'd0, 32'd0);
        check("t2_f_pred_still_taken", 64'(obs_pred), 64'(1));

        // OPP with stall suppresses delay-slot annul.
        step(0, 0, 1, 0, 1, 1, 32'd3, 32'd3);
        check("t3_cleardb_stalled", 64'(obs_cleardb), 64'(0));
        check("t3_branch_stalled", 64'(obs_branch), 64'(0));

        // Table-driven comparator vectors.
        foreach (vecs[i]) begin
            step(0, 0, 0, 0, 1, vecs[i].op, vecs[i].va, vecs[i].vb);
            check($sformatf("vec%0d_branch", i), 64'(obs_branch), 64'(vecs[i].exp_br));
            check($sformatf("vec%0d_cleardb", i), 64'(obs_cleardb), 64'(vecs[i].exp_cl));
        end

        // Mispredict then a 3-cycle stall: no count, no update.
        do_reset();
        step(9, 0, 0, 0, 0, 0, 32'd0, 32'd0);            // D: idx 9, pred NT
        step(9, 1, 0, 0, 1, 0, 32'd1, 32'd1);            // resolves taken -> mispredict
        check("t5_mp_count", 64'(mp_count), 64'(1));
        check("t5_br_count", 64'(br_count), 64'(1));
        for (int i = 0; i < 3; i++) step(9, 1, 1, 1, 1, 0, 32'd1, 32'd1);
        check("t5_mp_after_stall", 64'(mp_count), 64'(1));
        check("t5_br_after_stall", 64'(br_count), 64'(1));
        step(9, 1, 0, 0, 0, 0, 32'd0, 32'd0);
        check("t5_entry_one_update", 64'(obs_pred), 64'(1));

        // Mispredict counter wrap: pred NT, resolves taken every cycle.
        while (m_mp != (1 << CNT_W) - 1) step(0, 0, 0, 0, 1, 0, 32'd4, 32'd4);
        check("t6_mp_at_max", 64'(mp_count), 64'((1 << CNT_W) - 1));
        step(0, 0, 0, 0, 1, 0, 32'd4, 32'd4);
        check("t6_mp_wrapped", 64'(mp_count), 64'(0));

        // Reset asserted in the middle of a stalled branch.
        stall = 1'b1; d_valid = 1'b1; f_idx = 6'd0; f_is_br = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_br", 64'(br_count), 64'(0));
        check("t6_rst_mp", 64'(mp_count), 64'(0));
        check("t6_rst_f_pred", 64'(f_pred), 64'(0));
        check("t6_rst_mispredict", 64'(d_mispredict), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(0, 1, 0, 0, 0, 0, 32'd0, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ra, rb;
            ra = rand_word();
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = -ra;
                default: rb = rand_word();
            endcase
            step($urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
